codemem_loader: RTL

//  Writer side of the packet filter's instruction memory (codemem write port). Accepts a BPF program as an
//  AXI-Stream of IN_WIDTH-bit beats, packs BEATS=DATA_WIDTH/IN_WIDTH beats per instruction, writes them to

---
 rtl/codemem_loader_pkg.sv | 27 ++
 rtl/codemem_beat_packer.sv | 80 ++++++++
 rtl/codemem_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/codemem_loader_pkg.sv
// ============================================================================
// Module : codemem_loader_pkg
// Brief  : Shared state encoding, codemem width defaults and beat derivation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package codemem_loader_pkg;

  localparam int unsigned CODEMEM_ADDR_WIDTH = 10;
  localparam int unsigned CODEMEM_DATA_WIDTH = 64;
  localparam int unsigned LOADER_IN_WIDTH    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic int unsigned beats_per_word(input int unsigned data_w, input int unsigned in_w);
    return data_w / in_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/codemem_beat_packer.sv
// ============================================================================
// Module : codemem_beat_packer
// Brief  : Packs stream beats MSB-first into instruction words; word/word_valid
//          are combinational on the beat that completes a word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module codemem_beat_packer
  import codemem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = CODEMEM_DATA_WIDTH,
  parameter int IN_WIDTH   = LOADER_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_valid,
  input  logic                  flush,
  input  logic [IN_WIDTH-1:0]   beat_data,
  output logic                  at_last,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int BEATS = int'(beats_per_word(DATA_WIDTH, IN_WIDTH));
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  assign at_last    = (beat_cnt_q == LAST_CNT);
  assign word_valid = beat_valid & at_last;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      beat_cnt_d = '0;
    end else if (beat_valid) begin
      beat_cnt_d = at_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  generate
    if (BEATS > 1) begin : g_multi_beat
      localparam int PW = DATA_WIDTH - IN_WIDTH;
      // Only the leading BEATS-1 beats need storage; the final beat is spliced in live.
      logic [PW-1:0] prefix_q, prefix_d;

      assign word = {prefix_q, beat_data};

      always_comb begin
        prefix_d = prefix_q;
        if (beat_valid) begin
          prefix_d = word[PW-1:0];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          prefix_q <= '0;
        end else begin
          prefix_q <= prefix_d;
        end
      end
    end else begin : g_single_beat
      assign word = beat_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/codemem_loader.sv
// ============================================================================
// Module : codemem_loader
// Brief  : Streams a BPF program into codemem; tracks count, framing/overflow
//          errors. Optional XOR checksum port under CODEMEM_LOADER_CSUM_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module codemem_loader
  import codemem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = CODEMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = CODEMEM_DATA_WIDTH,
  parameter int IN_WIDTH   = LOADER_IN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
`ifdef CODEMEM_LOADER_CSUM_EN
  output logic [DATA_WIDTH-1:0] csum,
`endif
  output logic [ADDR_WIDTH:0]   inst_count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  generate
    if (DATA_WIDTH % IN_WIDTH != 0) begin : g_bad_width
      $error("codemem_loader: DATA_WIDTH must be a multiple of IN_WIDTH");
    end
  endgenerate

  state_e                  state_q, state_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [ADDR_WIDTH:0]     inst_count_q, inst_count_d;

  logic                    accept;
  logic                    feed;
  logic                    flush;
  logic                    at_last;
  logic                    word_valid;
  logic [DATA_WIDTH-1:0]   word;
  logic [ADDR_WIDTH:0]     count_base;

  assign s_axis_tready = load_en & ((state_q == ST_IDLE) | (state_q == ST_LOAD) | (state_q == ST_DRAIN));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign feed          = accept & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
  // A first beat in IDLE starts a fresh program, so the count seen by it is zero.
  assign count_base    = (state_q == ST_IDLE) ? '0 : inst_count_q;

  codemem_beat_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IN_WIDTH   (IN_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .beat_valid (feed),
    .flush      (flush),
    .beat_data  (s_axis_tdata),
    .at_last    (at_last),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    inst_count_d = inst_count_q;
    flush        = 1'b0;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          if (state_q == ST_IDLE) begin
            state_d      = ST_LOAD;
            busy_d       = 1'b1;
            err_d        = 1'b0;
            inst_count_d = '0;
          end
          if (word_valid) begin
            if (count_base == FULL_COUNT) begin
              err_d   = 1'b1;
              state_d = s_axis_tlast ? ST_FINISH : ST_DRAIN;
            end else begin
              wr_en_d      = 1'b1;
              wr_addr_d    = count_base[ADDR_WIDTH-1:0];
              wr_data_d    = word;
              inst_count_d = count_base + 1'b1;
              if (s_axis_tlast) begin
                state_d = ST_FINISH;
              end
            end
          end else if (s_axis_tlast) begin
            err_d   = 1'b1;
            flush   = 1'b1;
            state_d = ST_FINISH;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_axis_tlast) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign inst_count = inst_count_q;

`ifdef CODEMEM_LOADER_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (feed && (state_q == ST_IDLE)) begin
      csum_d = '0;
    end else if (wr_en_q) begin
      csum_d = csum_q ^ wr_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

endmodule

`default_nettype wire
